// File: rtl/adder_pkg.sv
// Shared constants and the word type for the 16-bit lookahead adder.
package adder_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int GRP_WIDTH = 4;
    localparam int NUM_GRP   = ADD_WIDTH / GRP_WIDTH;

    typedef logic [ADD_WIDTH-1:0] word_t;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead group: local sum bits, group generate/propagate, and
// the carry into the top bit (used by the top level for signed overflow).
module cla4
    import adder_pkg::*;
(
    input  logic [GRP_WIDTH-1:0] a,
    input  logic [GRP_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [GRP_WIDTH-1:0] s,
    output logic                 G,
    output logic                 P,
    output logic                 c3
);

    logic [GRP_WIDTH-1:0] g;
    logic [GRP_WIDTH-1:0] p;
    logic                 c1;
    logic                 c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum-of-products of g, p and cin; nothing ripples.
    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/adder_16.sv
// Registered 16-bit adder: four cla4 groups joined by a second-level lookahead.
// Define ADDER_STATUS_EN to add the registered COUT and OVF status outputs.
module adder_16
    import adder_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  word_t IN1,
    input  word_t IN2,
`ifdef ADDER_STATUS_EN
    output word_t OUT,
    output logic  COUT,
    output logic  OVF
`else
    output word_t OUT
`endif
);

    logic [NUM_GRP-1:0] grp_g;
    logic [NUM_GRP-1:0] grp_p;
    logic [NUM_GRP-1:0] grp_c3;
    logic [NUM_GRP:0]   grp_cin;
    word_t              sum;
    logic               unused_carry;

    // grp_cin[k] is the carry into group k; grp_cin[NUM_GRP] is c16.
    assign grp_cin[0] = 1'b0;
    assign grp_cin[1] = grp_g[0] | (grp_p[0] & grp_cin[0]);
    assign grp_cin[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                      | (grp_p[1] & grp_p[0] & grp_cin[0]);
    assign grp_cin[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                      | (grp_p[2] & grp_p[1] & grp_g[0])
                      | (grp_p[2] & grp_p[1] & grp_p[0] & grp_cin[0]);
    assign grp_cin[4] = grp_g[3] | (grp_p[3] & grp_g[2])
                      | (grp_p[3] & grp_p[2] & grp_g[1])
                      | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                      | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & grp_cin[0]);

    generate
        for (genvar i = 0; i < NUM_GRP; i++) begin : g_grp
            cla4 u_cla4 (
                .a   (IN1[i*GRP_WIDTH +: GRP_WIDTH]),
                .b   (IN2[i*GRP_WIDTH +: GRP_WIDTH]),
                .cin (grp_cin[i]),
                .s   (sum[i*GRP_WIDTH +: GRP_WIDTH]),
                .G   (grp_g[i]),
                .P   (grp_p[i]),
                .c3  (grp_c3[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT <= '0;
        end else begin
            OUT <= sum;
        end
    end

`ifdef ADDER_STATUS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            COUT <= 1'b0;
            OVF  <= 1'b0;
        end else begin
            COUT <= grp_cin[NUM_GRP];
            OVF  <= grp_cin[NUM_GRP] ^ grp_c3[NUM_GRP-1];
        end
    end

    assign unused_carry = ^grp_c3[NUM_GRP-2:0];
`else
    assign unused_carry = ^{grp_c3, grp_cin[NUM_GRP]};
`endif

endmodule

// File: tb/tb_adder_16.sv
// Self-checking bench for adder_16: directed vector table, reset sequences and
// random operands checked against an arithmetic reference model.
module tb_adder_16;

    logic        CLK;
    logic        RST;
    logic [15:0] IN1;
    logic [15:0] IN2;
    logic [15:0] OUT;
`ifdef ADDER_STATUS_EN
    logic        COUT;
    logic        OVF;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs [9];

    adder_16 dut (
        .CLK  (CLK),
        .RST  (RST),
        .IN1  (IN1),
        .IN2  (IN2),
`ifdef ADDER_STATUS_EN
        .OUT  (OUT),
        .COUT (COUT),
        .OVF  (OVF)
`else
        .OUT  (OUT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: integer addition, carry = bit 16 of the 17-bit sum,
    // overflow = operands share a sign that the result does not.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int unsigned full;
        logic [15:0] s;
        logic        c;
        logic        v;
        full = int'(a) + int'(b);
        s    = full[15:0];
        c    = (full >= 32'd65536);
        v    = (a[15] == b[15]) && (s[15] != a[15]);
        return {v, c, s};
    endfunction

    task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive operands after the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic rst, input logic [15:0] a, input logic [15:0] b);
        @(negedge CLK);
        RST = rst;
        IN1 = a;
        IN2 = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string name, input logic [15:0] s, input logic c, input logic v);
        check_word({name, ".out"}, OUT, s);
`ifdef ADDER_STATUS_EN
        check_bit({name, ".cout"}, COUT, c);
        check_bit({name, ".ovf"}, OVF, v);
`else
        if (c === 1'bx || v === 1'bx) $display("note: undefined status expectation in %s", name);
`endif
    endtask

    initial begin
        logic [17:0] r;
        logic [15:0] a;
        logic [15:0] b;

        vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'h0880, 16'h0244, 16'h0AC4, 1'b0, 1'b0};
        vecs[2] = '{16'h82A0, 16'h0A74, 16'h8D14, 1'b0, 1'b0};
        vecs[3] = '{16'h82A2, 16'h3E74, 16'hC116, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};

        RST = 1'b1;
        IN1 = 16'hFFFF;
        IN2 = 16'hFFFF;

        // Reset dominates the operands, then the first free cycle adds normally.
        apply(1'b1, 16'hFFFF, 16'hFFFF);
        check_all("reset", 16'h0000, 1'b0, 1'b0);
        apply(1'b0, 16'hFFFF, 16'hFFFF);
        check_all("post_reset", 16'hFFFE, 1'b1, 1'b0);

        // Back-to-back directed vectors: new operands every cycle.
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, vecs[i].a, vecs[i].b);
            check_all($sformatf("vec%0d", i), vecs[i].sum, vecs[i].c, vecs[i].v);
        end

        // One-cycle reset pulse mid-stream, then the sequence resumes.
        apply(1'b0, vecs[6].a, vecs[6].b);
        check_all("pre_pulse", vecs[6].sum, vecs[6].c, vecs[6].v);
        apply(1'b1, vecs[7].a, vecs[7].b);
        check_all("pulse", 16'h0000, 1'b0, 1'b0);
        apply(1'b0, vecs[8].a, vecs[8].b);
        check_all("resume", vecs[8].sum, vecs[8].c, vecs[8].v);
        apply(1'b0, vecs[3].a, vecs[3].b);
        check_all("resume2", vecs[3].sum, vecs[3].c, vecs[3].v);

        // Random operands, one add per cycle.
        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            apply(1'b0, a, b);
            r = ref_add(a, b);
            check_all($sformatf("rnd%0d_%h_%h", i, a, b), r[15:0], r[16], r[17]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_16.md
# adder_16

Registered 16-bit two's-complement/unsigned adder for the ALU datapath. It adds operands IN1 and IN2 modulo 2^16 and presents the sum on OUT one clock after the operands are sampled. The carry chain is an explicit 4-bit-group carry-lookahead network rather than a behavioural `+`. Optional carry/overflow status outputs are compiled in by macro.

## Interface
- Parameters: none. Width is fixed at 16 by package constants.
- CLK  input  1  rising-edge clock; the block has one clock.
- RST  input  1  reset, synchronous and active-high.
- IN1  input  16  operand A.
- IN2  input  16  operand B.
- OUT  output  16  registered sum, (IN1 + IN2) mod 2^16.
- COUT  output  1  registered carry out of bit 15. Present only with ADDER_STATUS_EN.
- OVF  output  1  registered signed overflow. Present only with ADDER_STATUS_EN.

## Operation
- Sum:
  - Unsigned and two's-complement addition are bit-identical.
  - The result wraps modulo 2^16.
  - Carry-in is fixed at 0.
- Per bit: generate g = a&b, propagate p = a^b, sum bit = p ^ c_in(bit).
- Inside each 4-bit group: c1..c4 are computed by lookahead equations from g, p and the group carry-in.
  - Group outputs are G and P.
- Across groups: group carry-ins c4, c8, c12 and c16 come from a second-level lookahead over the group G/P.
  - Group carries do not ripple.
- COUT = c16.
- OVF = c16 ^ c15. This equals 1 when both operands have the same sign bit and the sum bit 15 differs from it.
- No input validity handshake. Every cycle is an add.

## Timing
- Latency is 1 cycle.
  - Operands present before CLK edge n appear on OUT, COUT and OVF after edge n.
  - Throughput is one add per cycle.
- Reset:
  - If RST=1 at a rising edge, OUT=16'h0000, COUT=0 and OVF=0 after that edge, regardless of IN1 and IN2.
  - Reset asserted mid-stream discards the in-flight sum.
  - The first cycle after RST deasserts registers the current operands normally.
- Before the first reset edge, outputs are unspecified (X allowed).
- The combinational path IN→register fits one cycle. There is no internal state other than the output registers.

## Configuration
- ADDER_STATUS_EN:
  - Defined: the COUT and OVF ports and their registers exist, with reset value 0.
  - Undefined: those ports and registers are absent. OUT behaviour is identical in both builds.

## Structure
- Shared package adder_pkg:
  - ADD_WIDTH = 16
  - GRP_WIDTH = 4
  - NUM_GRP = 4
  - typedef word_t = logic [15:0]
- Sub-module cla4 (4-bit carry-lookahead group).
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], G, P, and c3 (the carry into the top bit, needed for OVF).
  - Instantiated 4×.
- The top level holds:
  - the second-level lookahead logic;
  - the output registers;
  - the macro-guarded status logic.

## Test plan
- Reset: RST=1 with IN1=16'hFFFF, IN2=16'hFFFF → after edge OUT=0x0000, COUT=0, OVF=0. Deassert → OUT=0xFFFE, COUT=1 next edge.
- Basic sums, each one cycle after apply:
  - 0x0000+0x0000 → 0x0000.
  - 0x0880+0x0244 → 0x0AC4 (2756).
  - 0x82A0+0x0A74 → 0x8D14 (36116).
  - 0x82A2+0x3E74 → 0xC116 (49430).
- Wrap and full carry chain: 0xFFFF+0x0001 → OUT=0x0000, COUT=1, OVF=0. 0x0FFF+0x0001 → 0x1000, exercising carry across group boundaries.
- Signed overflow:
  - 0x7FFF+0x0001 → 0x8000, OVF=1, COUT=0.
  - 0x8000+0x8000 → 0x0000, OVF=1, COUT=1.
  - 0xFFFF+0xFFFF → 0xFFFE, OVF=0.
- Back-to-back: change operands every cycle (above vectors consecutively) → each sum appears exactly one cycle later, no bubbles. RST pulsed for one cycle mid-sequence → that cycle's OUT=0, and the sequence resumes next cycle.
- Random: 10,000 random pairs compared against a modulo-2^16 reference, plus status bits when ADDER_STATUS_EN is defined. Run the build both with and without the macro.
